// File: rtl/source2_pkg.sv
// Shared types and helpers for the two-phase source endpoint.
// State encodings match the ones used by the matching sink endpoints.
package source2_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // The gap counter only needs to hold GAP-1, but never shrinks below one bit.
    function automatic int gap_width(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/source2_if.sv
// Two-phase req/ack link carrying one data word per request toggle.
interface source2_if #(
    parameter int SIZE = 8
);
    logic            req;
    logic            ack;
    logic [SIZE-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/source2.sv
// Two-phase transmitter: sends START, START+STEP, ... one word per req toggle,
// optionally stopping after COUNT words and idling GAP cycles between words.
module source2
    import source2_pkg::*;
#(
    parameter int ID    = 0,
    parameter int SIZE  = 8,
    parameter int COUNT = 0,
    parameter int GAP   = 0,
    parameter int START = 0,
    parameter int STEP  = 1,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    source2_if.master     link,
    output logic [CW-1:0] count,
    output logic          done
);

    localparam int              GW       = gap_width(GAP);
    localparam logic [SIZE-1:0] START_V  = SIZE'(START);
    localparam logic [SIZE-1:0] STEP_V   = SIZE'(STEP);
    localparam logic [CW-1:0]   COUNT_V  = CW'(COUNT);
    localparam logic [GW-1:0]   GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t          state;
    logic            req_q;
    logic [SIZE-1:0] data_q;
    logic [GW-1:0]   gap_cnt;
    logic [CW-1:0]   count_next;

    // ID only labels simulation messages, so it has no hardware effect.
    logic unused_id;
    assign unused_id = ^ID;

    assign count_next = count + CW'(1);
    assign link.req   = req_q;
    assign link.data  = data_q;

    // IDLE also waits for ack == req, so a spurious ack change just parks the
    // block until the link looks idle again instead of double-toggling req.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            req_q   <= 1'b0;
            data_q  <= START_V;
            count   <= '0;
            done    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && !done && (req_q == link.ack)) begin
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    req_q <= ~req_q;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (link.ack == req_q) begin
                        count  <= count_next;
                        data_q <= data_q + STEP_V;
                        if ((COUNT != 0) && (count_next == COUNT_V)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (GAP > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_source2.sv
// Bench for source2: three instances (fixed-count, wrapping, gapped/unlimited)
// each talking to a behavioural two-phase receiver.
module tb_source2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b, en_c;
    logic [15:0] count_a, count_b, count_c;
    logic        done_a, done_b, done_c;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    source2_if #(.SIZE(8)) la ();
    source2_if #(.SIZE(8)) lb ();
    source2_if #(.SIZE(8)) lc ();

    source2 #(.ID(1), .SIZE(8), .COUNT(4), .GAP(0), .START(5), .STEP(1), .CW(16)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .link(la), .count(count_a), .done(done_a));
    source2 #(.ID(2), .SIZE(8), .COUNT(3), .GAP(0), .START(254), .STEP(1), .CW(16)) u_b (
        .clk(clk), .reset(reset), .en(en_b), .link(lb), .count(count_b), .done(done_b));
    source2 #(.ID(3), .SIZE(8), .COUNT(0), .GAP(3), .START(16), .STEP(3), .CW(16)) u_c (
        .clk(clk), .reset(reset), .en(en_c), .link(lc), .count(count_c), .done(done_c));

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Receivers: acknowledge one edge after a new request is seen (C adds a random delay).
    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    logic [7:0] rx_c[$];
    int         c_wait = 0;
    int         c_delay_max = 0;

    always @(posedge clk) begin
        if (!reset) begin
            la.ack <= 1'b0;
            rx_a.delete();
        end else if (la.req !== la.ack) begin
            la.ack <= la.req;
            rx_a.push_back(la.data);
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            lb.ack <= 1'b0;
            rx_b.delete();
        end else if (lb.req !== lb.ack) begin
            lb.ack <= lb.req;
            rx_b.push_back(lb.data);
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            lc.ack <= 1'b0;
            c_wait <= 0;
            rx_c.delete();
        end else if (lc.req !== lc.ack) begin
            if (c_wait == 0) begin
                lc.ack <= lc.req;
                rx_c.push_back(lc.data);
                c_wait <= $urandom_range(0, c_delay_max);
            end else begin
                c_wait <= c_wait - 1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // While a word is outstanding it must be the next word of the sequence.
    always @(negedge clk) begin
        if (reset === 1'b1 && lc.req !== lc.ack) begin
            check_output("c data stable", 32'(lc.data), (16 + rx_c.size() * 3) % 256);
        end
    end

    int   tog_c[$];
    logic prev_req_c;
    always @(negedge clk) begin
        if (lc.req !== prev_req_c) tog_c.push_back(cycle);
        prev_req_c <= lc.req;
    end

    typedef struct {
        int          cyc;
        logic        en;
        logic        req;
        logic [7:0]  data;
        logic [15:0] count;
        logic        done;
    } vec_t;

    vec_t vec_a[14];
    int   cyc_a = 0;

    task automatic apply_stimulus(input vec_t v);
        while (cyc_a < v.cyc) begin
            @(negedge clk);
            cyc_a++;
        end
        check_output($sformatf("a req @%0d", v.cyc), 32'(la.req), 32'(v.req));
        check_output($sformatf("a data @%0d", v.cyc), 32'(la.data), 32'(v.data));
        check_output($sformatf("a count @%0d", v.cyc), 32'(count_a), 32'(v.count));
        check_output($sformatf("a done @%0d", v.cyc), 32'(done_a), 32'(v.done));
        en_a = v.en;
    endtask

    task automatic wait_toggle(input int bound, output logic found);
        logic r0;
        r0    = lc.req;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (lc.req !== r0) found = 1'b1;
        end
    endtask

    initial begin
        logic        found;
        logic        held_req;
        logic [15:0] n0;
        int          start_cyc;
        logic [7:0]  exp_b[3];

        // req toggles every 4 edges; count/data advance on the edge the ack is seen.
        vec_a[0]  = '{0,  1'b1, 1'b0, 8'd5, 16'd0, 1'b0};
        vec_a[1]  = '{1,  1'b1, 1'b0, 8'd5, 16'd0, 1'b0};
        vec_a[2]  = '{2,  1'b1, 1'b1, 8'd5, 16'd0, 1'b0};
        vec_a[3]  = '{3,  1'b1, 1'b1, 8'd5, 16'd0, 1'b0};
        vec_a[4]  = '{4,  1'b1, 1'b1, 8'd6, 16'd1, 1'b0};
        vec_a[5]  = '{5,  1'b1, 1'b1, 8'd6, 16'd1, 1'b0};
        vec_a[6]  = '{6,  1'b1, 1'b0, 8'd6, 16'd1, 1'b0};
        vec_a[7]  = '{8,  1'b1, 1'b0, 8'd7, 16'd2, 1'b0};
        vec_a[8]  = '{10, 1'b1, 1'b1, 8'd7, 16'd2, 1'b0};
        vec_a[9]  = '{12, 1'b1, 1'b1, 8'd8, 16'd3, 1'b0};
        vec_a[10] = '{14, 1'b1, 1'b0, 8'd8, 16'd3, 1'b0};
        vec_a[11] = '{15, 1'b1, 1'b0, 8'd8, 16'd3, 1'b0};
        vec_a[12] = '{16, 1'b0, 1'b0, 8'd9, 16'd4, 1'b1};
        vec_a[13] = '{20, 1'b0, 1'b0, 8'd9, 16'd4, 1'b1};
        exp_b[0] = 8'd254;
        exp_b[1] = 8'd255;
        exp_b[2] = 8'd0;

        reset = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        en_c  = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst c req", 32'(lc.req), 0);
        check_output("rst c data", 32'(lc.data), 16);
        check_output("rst b data", 32'(lb.data), 254);
        check_output("rst c count", 32'(count_c), 0);
        check_output("rst c done", 32'(done_c), 0);

        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("idle a req", 32'(la.req), 0);
            check_output("idle a data", 32'(la.data), 5);
            check_output("idle a count", 32'(count_a), 0);
            check_output("idle a done", 32'(done_a), 0);
        end

        for (int i = 0; i < 14; i++) apply_stimulus(vec_a[i]);
        check_output("a rx size", rx_a.size(), 4);
        for (int i = 0; i < rx_a.size(); i++) check_output("a rx word", 32'(rx_a[i]), 5 + i);
        check_output("a req==ack", 32'(la.req == la.ack), 1);

        en_b = 1'b1;
        for (int i = 0; i < 60 && !done_b; i++) @(negedge clk);
        en_b = 1'b0;
        check_output("b done", 32'(done_b), 1);
        check_output("b count", 32'(count_b), 3);
        check_output("b next data", 32'(lb.data), 1);
        check_output("b rx size", rx_b.size(), 3);
        for (int i = 0; i < rx_b.size() && i < 3; i++) check_output("b rx word", 32'(rx_b[i]), 32'(exp_b[i]));
        check_output("b req==ack", 32'(lb.req == lb.ack), 1);

        // Gap spacing with a prompt receiver.
        tog_c.delete();
        start_cyc = cycle;
        en_c = 1'b1;
        repeat (40) @(negedge clk);
        check_output("c toggles", 32'(tog_c.size() >= 5), 1);
        if (tog_c.size() > 0) check_output("c first toggle", tog_c[0] - start_cyc, 2);
        for (int i = 1; i < tog_c.size() && i < 5; i++)
            check_output("c toggle spacing", tog_c[i] - tog_c[i-1], 7);

        // Drop en just after a request toggle: that transfer still completes.
        wait_toggle(20, found);
        check_output("c toggle before drop", 32'(found), 1);
        held_req = lc.req;
        n0 = count_c;
        en_c = 1'b0;
        repeat (30) @(negedge clk);
        check_output("c count after drop", 32'(count_c), 32'(n0 + 16'd1));
        check_output("c req held", 32'(lc.req), 32'(held_req));
        check_output("c idle req==ack", 32'(lc.req == lc.ack), 1);
        en_c = 1'b1;
        wait_toggle(4, found);
        check_output("c resume toggle", 32'(found), 1);

        // Reset while the transfer is outstanding.
        reset = 1'b0;
        @(negedge clk);
        check_output("mid rst req", 32'(lc.req), 0);
        check_output("mid rst count", 32'(count_c), 0);
        check_output("mid rst data", 32'(lc.data), 16);
        check_output("mid rst a done", 32'(done_a), 0);
        reset = 1'b1;

        c_delay_max = 4;
        for (int i = 0; i < 400; i++) begin
            en_c = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        en_c = 1'b0;
        repeat (40) @(negedge clk);
        check_output("rand progress", 32'(rx_c.size() >= 15), 1);
        check_output("rand count", 32'(count_c), 32'(rx_c.size()));
        check_output("rand req==ack", 32'(lc.req == lc.ack), 1);
        check_output("rand done low", 32'(done_c), 0);
        for (int i = 0; i < rx_c.size(); i++)
            check_output($sformatf("rand rx[%0d]", i), 32'(rx_c[i]), (16 + 3 * i) % 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
